// File: rtl/bus_rr_interconnect.sv
// Round-robin multi-host to multi-device bus interconnect with one outstanding
// transaction, mask/base address decode and a device response timeout.
module bus_rr_interconnect #(
  parameter int NrDevices     = 4,
  parameter int NrHosts       = 2,
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    host_req_i           [NrHosts],
  output logic                    host_gnt_o           [NrHosts],
  input  logic [AddressWidth-1:0] host_addr_i          [NrHosts],
  input  logic                    host_we_i            [NrHosts],
  input  logic [DataWidth/8-1:0]  host_be_i            [NrHosts],
  input  logic [DataWidth-1:0]    host_wdata_i         [NrHosts],
  output logic                    host_rvalid_o        [NrHosts],
  output logic [DataWidth-1:0]    host_rdata_o         [NrHosts],
  output logic                    host_err_o           [NrHosts],
  output logic                    device_req_o         [NrDevices],
  output logic [AddressWidth-1:0] device_addr_o        [NrDevices],
  output logic                    device_we_o          [NrDevices],
  output logic [DataWidth/8-1:0]  device_be_o          [NrDevices],
  output logic [DataWidth-1:0]    device_wdata_o       [NrDevices],
  input  logic                    device_rvalid_i      [NrDevices],
  input  logic [DataWidth-1:0]    device_rdata_i       [NrDevices],
  input  logic                    device_err_i         [NrDevices],
  input  logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices]
);

  localparam int HostW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int DevW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
  localparam int CntW  = $clog2(TimeoutCycles + 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [HostW-1:0]       last_grant_q, last_grant_d;
  logic [HostW-1:0]       owner_q, owner_d;
  logic [DevW-1:0]        sel_q, sel_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   rvalid_q [NrHosts];
  logic                   rvalid_d [NrHosts];
  logic [DataWidth-1:0]   rdata_q  [NrHosts];
  logic [DataWidth-1:0]   rdata_d  [NrHosts];
  logic                   err_q    [NrHosts];
  logic                   err_d    [NrHosts];

  logic [HostW-1:0]       cand_s;
  logic [HostW-1:0]       winner_s;
  logic                   any_req_s;
  logic [DevW-1:0]        dev_s;
  logic                   hit_s;
  logic                   match_s;

  // Scan backwards so the requester closest after last_grant is the final assignment.
  always_comb begin
    any_req_s = 1'b0;
    winner_s  = '0;
    cand_s    = '0;
    for (int i = NrHosts; i >= 1; i--) begin
      cand_s    = HostW'((int'(last_grant_q) + i) % NrHosts);
      any_req_s = any_req_s | host_req_i[cand_s];
      winner_s  = host_req_i[cand_s] ? cand_s : winner_s;
    end
  end

  // Address decode of the winning host; descending scan leaves the lowest match.
  always_comb begin
    hit_s   = 1'b0;
    dev_s   = '0;
    match_s = 1'b0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      match_s = ((host_addr_i[winner_s] & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]);
      hit_s   = hit_s | match_s;
      dev_s   = match_s ? DevW'(d) : dev_s;
    end
  end

  // Next-state, grant, forwarding and response capture.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    for (int h = 0; h < NrHosts; h++) begin
      host_gnt_o[h] = 1'b0;
      rvalid_d[h]   = 1'b0;
      rdata_d[h]    = '0;
      err_d[h]      = 1'b0;
    end
    for (int d = 0; d < NrDevices; d++) begin
      device_req_o[d]   = 1'b0;
      device_addr_o[d]  = '0;
      device_we_o[d]    = 1'b0;
      device_be_o[d]    = '0;
      device_wdata_o[d] = '0;
    end
    case (state_q)
      ST_IDLE: begin
        if (rst_ni && any_req_s) begin
          host_gnt_o[winner_s] = 1'b1;
          last_grant_d         = winner_s;
          owner_d              = winner_s;
          if (hit_s) begin
            device_req_o[dev_s]   = 1'b1;
            device_addr_o[dev_s]  = host_addr_i[winner_s];
            device_we_o[dev_s]    = host_we_i[winner_s];
            device_be_o[dev_s]    = host_be_i[winner_s];
            device_wdata_o[dev_s] = host_wdata_i[winner_s];
            sel_d                 = dev_s;
            cnt_d                 = '0;
            state_d               = ST_WAIT;
          end else begin
            rvalid_d[winner_s] = 1'b1;
            err_d[winner_s]    = 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_WAIT: begin
        // A response arriving on the last allowed cycle still beats the timeout.
        if (device_rvalid_i[sel_q]) begin
          rvalid_d[owner_q] = 1'b1;
          rdata_d[owner_q]  = device_rdata_i[sel_q];
          err_d[owner_q]    = device_err_i[sel_q];
          state_d           = ST_IDLE;
        end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          rvalid_d[owner_q] = 1'b1;
          err_d[owner_q]    = 1'b1;
          state_d           = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and response registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      last_grant_q <= HostW'(NrHosts - 1);
      owner_q      <= '0;
      sel_q        <= '0;
      cnt_q        <= '0;
      for (int h = 0; h < NrHosts; h++) begin
        rvalid_q[h] <= 1'b0;
        rdata_q[h]  <= '0;
        err_q[h]    <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      for (int h = 0; h < NrHosts; h++) begin
        rvalid_q[h] <= rvalid_d[h];
        rdata_q[h]  <= rdata_d[h];
        err_q[h]    <= err_d[h];
      end
    end
  end

  assign host_rvalid_o = rvalid_q;
  assign host_rdata_o  = rdata_q;
  assign host_err_o    = err_q;

endmodule

// File: tb/tb_bus_rr_interconnect.sv
// Self-checking bench for bus_rr_interconnect: vector table, directed corner
// sequences and a randomized run against a cycle-stamped transaction model.
module tb_bus_rr_interconnect;

  localparam int NH = 2;
  localparam int ND = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic          host_req_i      [NH];
  logic          host_gnt_o      [NH];
  logic [AW-1:0] host_addr_i     [NH];
  logic          host_we_i       [NH];
  logic [3:0]    host_be_i       [NH];
  logic [DW-1:0] host_wdata_i    [NH];
  logic          host_rvalid_o   [NH];
  logic [DW-1:0] host_rdata_o    [NH];
  logic          host_err_o      [NH];
  logic          device_req_o    [ND];
  logic [AW-1:0] device_addr_o   [ND];
  logic          device_we_o     [ND];
  logic [3:0]    device_be_o     [ND];
  logic [DW-1:0] device_wdata_o  [ND];
  logic          device_rvalid_i [ND];
  logic [DW-1:0] device_rdata_i  [ND];
  logic          device_err_i    [ND];
  logic [AW-1:0] cfg_base        [ND];
  logic [AW-1:0] cfg_mask        [ND];

  always #5 clk = ~clk;

  bus_rr_interconnect #(
    .NrDevices(ND), .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
    .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .device_req_o(device_req_o), .device_addr_o(device_addr_o), .device_we_o(device_we_o),
    .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
    .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i), .device_err_i(device_err_i),
    .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NH-1:0] gnt_v();
    logic [NH-1:0] v;
    for (int h = 0; h < NH; h++) v[h] = host_gnt_o[h];
    return v;
  endfunction

  function automatic logic [NH-1:0] rv_v();
    logic [NH-1:0] v;
    for (int h = 0; h < NH; h++) v[h] = host_rvalid_o[h];
    return v;
  endfunction

  function automatic logic [NH-1:0] err_v();
    logic [NH-1:0] v;
    for (int h = 0; h < NH; h++) v[h] = host_err_o[h];
    return v;
  endfunction

  function automatic logic [ND-1:0] dreq_v();
    logic [ND-1:0] v;
    for (int d = 0; d < ND; d++) v[d] = device_req_o[d];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int h = 0; h < NH; h++) begin
      host_req_i[h] = 1'b0; host_addr_i[h] = '0; host_we_i[h] = 1'b0;
      host_be_i[h] = 4'hF; host_wdata_i[h] = '0;
    end
    for (int d = 0; d < ND; d++) begin
      device_rvalid_i[d] = 1'b0; device_rdata_i[d] = '0; device_err_i[d] = 1'b0;
    end
  endtask

  task automatic set_map_default();
    for (int d = 0; d < ND; d++) begin
      cfg_base[d] = 32'(d) << 28;
      cfg_mask[d] = 32'hF000_0000;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [1:0]  gnt;
    logic [3:0]  dreq;
    logic [1:0]  rv;
    logic        err;
  } vec_t;

  vec_t vecs [7];

  // model state for the randomized run
  int          m_last, m_owner, m_sel, m_start, w, dsel;
  bit          m_busy, quiet;
  bit          p_v, np_v, p_e, np_e;
  int          p_h, np_h;
  logic [31:0] p_d, np_d;
  bit          hold [NH];
  logic [NH-1:0] eg;
  logic [ND-1:0] ed;
  logic [3:0]  pfx;
  logic [1:0]  exp_g, exp_r;

  initial begin
    vecs[0] = '{2'b01, 32'h1000_0004, 32'h0,         2'b01, 4'b0010, 2'b00, 1'b0};
    vecs[1] = '{2'b10, 32'h0,         32'hF000_0000, 2'b10, 4'b0000, 2'b10, 1'b1};
    vecs[2] = '{2'b11, 32'h3000_0000, 32'h1000_0000, 2'b01, 4'b1000, 2'b00, 1'b0};
    vecs[3] = '{2'b10, 32'h0,         32'h2000_0010, 2'b10, 4'b0100, 2'b00, 1'b0};
    vecs[4] = '{2'b00, 32'h1000_0000, 32'h2000_0000, 2'b00, 4'b0000, 2'b00, 1'b0};
    vecs[5] = '{2'b01, 32'h0ABC_0000, 32'h0,         2'b01, 4'b0001, 2'b00, 1'b0};
    vecs[6] = '{2'b11, 32'h4000_0000, 32'h0,         2'b01, 4'b0000, 2'b01, 1'b1};

    set_map_default();
    idle_inputs();
    rst_n = 1'b0;
    host_req_i[0] = 1'b1;
    host_req_i[1] = 1'b1;
    tick();
    tick();
    settle();
    chk("reset_gnt", gnt_v(), 2'b00);
    chk("reset_dreq", dreq_v(), 4'b0000);
    chk("reset_rvalid", rv_v(), 2'b00);
    chk("reset_err", err_v(), 2'b00);
    chk("reset_rdata", {host_rdata_o[1], host_rdata_o[0]}, 64'h0);
    tick();

    // single-grant vectors, each from a fresh reset
    for (int i = 0; i < 7; i++) begin
      do_reset();
      host_req_i[0]  = vecs[i].req[0];
      host_req_i[1]  = vecs[i].req[1];
      host_addr_i[0] = vecs[i].addr0;
      host_addr_i[1] = vecs[i].addr1;
      settle();
      chk("vec_gnt", gnt_v(), vecs[i].gnt);
      chk("vec_dreq", dreq_v(), vecs[i].dreq);
      tick();
      idle_inputs();
      settle();
      chk("vec_rvalid", rv_v(), vecs[i].rv);
      chk("vec_err", err_v(), vecs[i].err ? vecs[i].rv : 2'b00);
      chk("vec_rdata", {host_rdata_o[1], host_rdata_o[0]}, 64'h0);
      tick();
    end

    // both hosts request continuously, device 0 answers one cycle after its request
    do_reset();
    for (int h = 0; h < NH; h++) begin
      host_req_i[h]  = 1'b1;
      host_addr_i[h] = 32'h0000_0100;
    end
    for (int k = 0; k < 10; k++) begin
      device_rvalid_i[0] = (k % 2 == 1);
      device_rdata_i[0]  = 32'hA0 + 32'(k);
      settle();
      exp_g = (k % 2 == 0) ? (((k / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_r = (k >= 2 && k % 2 == 0) ? ((((k / 2) - 1) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk("rr_gnt", gnt_v(), exp_g);
      chk("rr_dreq", dreq_v(), (k % 2 == 0) ? 4'b0001 : 4'b0000);
      chk("rr_rvalid", rv_v(), exp_r);
      if (exp_r != 2'b00) chk("rr_rdata", host_rdata_o[exp_r == 2'b01 ? 0 : 1], 32'hA0 + 32'(k) - 32'd1);
      tick();
    end

    // host 0 read from device 1, with a stray response from device 0
    do_reset();
    host_req_i[0] = 1'b1; host_addr_i[0] = 32'h1000_0004;
    host_be_i[0] = 4'b0110; host_wdata_i[0] = 32'h1234_5678;
    settle();
    chk("rd_gnt", gnt_v(), 2'b01);
    chk("rd_dreq", dreq_v(), 4'b0010);
    chk("rd_be", device_be_o[1], 4'b0110);
    chk("rd_addr", device_addr_o[1], 32'h1000_0004);
    chk("rd_other_be", device_be_o[0], 4'b0000);
    tick();
    host_req_i[0] = 1'b0;
    device_rvalid_i[1] = 1'b1; device_rdata_i[1] = 32'hDEAD_BEEF; device_err_i[1] = 1'b0;
    device_rvalid_i[0] = 1'b1; device_rdata_i[0] = 32'hBAD0_0000; device_err_i[0] = 1'b1;
    settle();
    chk("rd_wait_rvalid", rv_v(), 2'b00);
    tick();
    idle_inputs();
    settle();
    chk("rd_rvalid", rv_v(), 2'b01);
    chk("rd_rdata", host_rdata_o[0], 32'hDEAD_BEEF);
    chk("rd_err", err_v(), 2'b00);
    chk("rd_nonowner_rdata", host_rdata_o[1], 32'h0);
    tick();
    settle();
    chk("rd_pulse", rv_v(), 2'b00);
    tick();

    // device never answers: timeout response 17 cycles after grant, late rvalid ignored
    do_reset();
    host_req_i[0] = 1'b1; host_addr_i[0] = 32'h0000_0040;
    settle();
    chk("to_gnt", gnt_v(), 2'b01);
    tick();
    host_req_i[0] = 1'b0;
    for (int k = 1; k < 21; k++) begin
      device_rvalid_i[0] = (k == 18);
      settle();
      chk("to_rvalid", rv_v(), (k == 17) ? 2'b01 : 2'b00);
      if (k == 17) begin
        chk("to_err", err_v(), 2'b01);
        chk("to_rdata", host_rdata_o[0], 32'h0);
      end
      tick();
    end

    // reset during WAIT drops the transaction and restarts arbitration at host 0
    do_reset();
    for (int h = 0; h < NH; h++) begin
      host_req_i[h] = 1'b1; host_addr_i[h] = 32'h0000_0000;
    end
    settle();
    chk("rst_first_gnt", gnt_v(), 2'b01);
    tick();
    rst_n = 1'b0;
    settle();
    chk("rst_gnt_low", gnt_v(), 2'b00);
    chk("rst_dreq_low", dreq_v(), 4'b0000);
    tick();
    rst_n = 1'b1;
    device_rvalid_i[0] = 1'b1;
    settle();
    chk("rst_regrant", gnt_v(), 2'b01);
    chk("rst_no_rvalid", rv_v(), 2'b00);
    tick();
    device_rvalid_i[0] = 1'b0;
    settle();
    chk("rst_stray_ignored", rv_v(), 2'b00);
    tick();

    // overlapping windows: lowest device wins and its error is reported
    do_reset();
    cfg_base[0] = 32'h4000_0000; cfg_mask[0] = 32'hF000_0000;
    cfg_base[1] = 32'h4000_0000; cfg_mask[1] = 32'hFF00_0000;
    host_req_i[0] = 1'b1; host_addr_i[0] = 32'h4000_1000;
    settle();
    chk("ovl_dreq", dreq_v(), 4'b0001);
    tick();
    host_req_i[0] = 1'b0;
    device_rvalid_i[0] = 1'b1; device_err_i[0] = 1'b1; device_rdata_i[0] = 32'h5555_0000;
    device_rvalid_i[1] = 1'b1; device_err_i[1] = 1'b0; device_rdata_i[1] = 32'h1111_1111;
    tick();
    idle_inputs();
    settle();
    chk("ovl_rvalid", rv_v(), 2'b01);
    chk("ovl_err", err_v(), 2'b01);
    chk("ovl_rdata", host_rdata_o[0], 32'h5555_0000);
    tick();
    set_map_default();

    // randomized traffic against the transaction model
    do_reset();
    m_last = NH - 1; m_busy = 1'b0; p_v = 1'b0; quiet = 1'b0;
    m_owner = 0; m_sel = 0; m_start = 0; p_h = 0; p_d = '0; p_e = 1'b0;
    for (int h = 0; h < NH; h++) hold[h] = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (t % 64 == 0) quiet = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      for (int h = 0; h < NH; h++) begin
        if (!hold[h]) begin
          hold[h] = ($urandom_range(0, 2) != 0);
          pfx = ($urandom_range(0, 5) == 5) ? 4'hF : 4'($urandom_range(0, 4));
          host_addr_i[h]  = {pfx, 28'($urandom)};
          host_we_i[h]    = 1'($urandom);
          host_be_i[h]    = 4'($urandom);
          host_wdata_i[h] = $urandom;
        end
        host_req_i[h] = hold[h];
      end
      for (int d = 0; d < ND; d++) begin
        device_rvalid_i[d] = !quiet && ($urandom_range(0, 2) == 0);
        device_rdata_i[d]  = $urandom;
        device_err_i[d]    = ($urandom_range(0, 3) == 0);
      end
      settle();
      for (int h = 0; h < NH; h++) begin
        chk("rnd_rvalid", host_rvalid_o[h], (p_v && p_h == h) ? 1'b1 : 1'b0);
        chk("rnd_rdata", host_rdata_o[h], (p_v && p_h == h) ? p_d : 32'h0);
        chk("rnd_err", host_err_o[h], (p_v && p_h == h) ? p_e : 1'b0);
      end
      eg = '0; ed = '0; np_v = 1'b0; np_h = 0; np_d = '0; np_e = 1'b0; w = -1;
      if (!rst_n) begin
        m_busy = 1'b0;
        m_last = NH - 1;
      end else if (m_busy) begin
        if (device_rvalid_i[m_sel]) begin
          np_v = 1'b1; np_h = m_owner; np_d = device_rdata_i[m_sel]; np_e = device_err_i[m_sel];
          m_busy = 1'b0;
        end else if (t - m_start == TO) begin
          np_v = 1'b1; np_h = m_owner; np_e = 1'b1;
          m_busy = 1'b0;
        end
      end else begin
        for (int i = 1; i <= NH; i++)
          if (w < 0 && host_req_i[(m_last + i) % NH]) w = (m_last + i) % NH;
        if (w >= 0) begin
          eg[w] = 1'b1;
          m_last = w;
          dsel = -1;
          for (int d = 0; d < ND; d++)
            if (dsel < 0 && (host_addr_i[w] & cfg_mask[d]) == cfg_base[d]) dsel = d;
          if (dsel >= 0) begin
            ed[dsel] = 1'b1; m_busy = 1'b1; m_owner = w; m_sel = dsel; m_start = t;
          end else begin
            np_v = 1'b1; np_h = w; np_e = 1'b1;
          end
        end
      end
      chk("rnd_gnt", gnt_v(), eg);
      chk("rnd_dreq", dreq_v(), ed);
      for (int d = 0; d < ND; d++) begin
        chk("rnd_daddr", device_addr_o[d], ed[d] ? host_addr_i[w] : 32'h0);
        chk("rnd_dfields", {device_we_o[d], device_be_o[d], device_wdata_o[d]},
            ed[d] ? {host_we_i[w], host_be_i[w], host_wdata_i[w]} : 37'h0);
      end
      p_v = np_v; p_h = np_h; p_d = np_d; p_e = np_e;
      for (int h = 0; h < NH; h++) if (eg[h]) hold[h] = 1'b0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_rr_interconnect.md
BUS_RR_INTERCONNECT -- requirements
Module: bus_rr_interconnect

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NrDevices, 4, device ports
- NrHosts, 2, host ports
- DataWidth, 32, data bits (multiple of 8)
- AddressWidth, 32, address bits
- TimeoutCycles, 16, maximum cycles waiting for a device response (≥2)
REQ-002 Ports SHALL be (name, direction, width, meaning); per-host and per-device signals are unpacked arrays [NrHosts] / [NrDevices]:
- clk_i, in, 1, sole clock
- rst_ni, in, 1, synchronous active-low reset
- host_req_i, in, 1, host request
- host_gnt_o, out, 1, request accepted
- host_addr_i, in, AddressWidth, address
- host_we_i, in, 1, write enable
- host_be_i, in, DataWidth/8, byte enables
- host_wdata_i, in, DataWidth, write data
- host_rvalid_o, out, 1, response valid, one-cycle pulse
- host_rdata_o, out, DataWidth, read data
- host_err_o, out, 1, error response
- device_req_o, out, 1, device request, one-cycle pulse
- device_addr_o, out, AddressWidth, forwarded address
- device_we_o, out, 1, forwarded write enable
- device_be_o, out, DataWidth/8, forwarded byte enables
- device_wdata_o, out, DataWidth, forwarded write data
- device_rvalid_i, in, 1, device response valid
- device_rdata_i, in, DataWidth, device read data
- device_err_i, in, 1, device error
- cfg_device_addr_base, in, AddressWidth, device base address
- cfg_device_addr_mask, in, AddressWidth, device address mask
REQ-003 Clocking and reset are fixed: single clock clk_i; reset rst_ni is synchronous and active-low.

Function
REQ-004 States SHALL be IDLE and WAIT; one transaction is outstanding at most.
REQ-005 In IDLE, arbitration SHALL be round-robin among asserted host_req_i: the search starts at last_grant+1 (mod NrHosts), and the first requester found wins.
REQ-006 In IDLE with any request, host_gnt_o[winner] SHALL be 1 in the same cycle (combinational); all other grants SHALL be 0; last_grant SHALL be updated to winner at the clock edge.
REQ-007 Decode: device d matches when (addr & mask[d]) == base[d]; if several devices match, the lowest index SHALL win.
REQ-008 On a grant with a decode hit, device_req_o[sel] SHALL be 1 the same cycle, carrying the winner's addr/we/be/wdata; all other device outputs SHALL be 0. The owner and sel SHALL be registered, and the state SHALL go to WAIT.
REQ-009 On a grant with a decode miss:
- no device_req_o is asserted
- next cycle: host_rvalid_o[owner]=1, host_err_o=1, host_rdata_o=0
- state remains IDLE
REQ-010 In WAIT:
- all host_gnt_o and device_req_o SHALL be 0
- requests SHALL be held off (hosts keep req asserted until gnt)
REQ-011 In WAIT, when device_rvalid_i[sel]=1:
- device_rdata_i and device_err_i SHALL be registered
- next cycle: host_rvalid_o[owner]=1 with that data and err
- state SHALL return to IDLE
REQ-012 The response SHALL therefore arrive on host_rvalid_o one cycle after device_rvalid_i. Minimum grant-to-rvalid latency is 2 cycles.
REQ-013 A timeout counter SHALL clear on entry to WAIT and increment each WAIT cycle. If it reaches TimeoutCycles without device_rvalid_i[sel]:
- next cycle: host_rvalid_o[owner]=1, err=1, rdata=0
- state SHALL go to IDLE
REQ-014 device_rvalid_i from a non-selected device, or any device_rvalid_i in IDLE (late or stray), SHALL be ignored.
REQ-015 A new grant SHALL be allowed in the same cycle that host_rvalid_o of the previous transaction is high.
REQ-016 host_rvalid_o SHALL be a single-cycle pulse. For non-owner hosts, host_rdata_o and host_err_o SHALL be 0.
REQ-017 A read/write distinction SHALL NOT alter the protocol: writes also receive an rvalid response.

Reset
REQ-018 When rst_ni=0 at a clock edge, the block SHALL be placed in this state:
- state=IDLE
- last_grant=NrHosts-1, so host 0 wins first
- timeout counter=0
- all host_rvalid_o/host_err_o/host_rdata_o = 0
Any in-flight transaction SHALL be dropped with no response.
REQ-019 While rst_ni=0, host_gnt_o and device_req_o SHALL be 0.

Verification
REQ-020 After reset, hosts 0 and 1 request continuously, all addresses mapped to device 0, which responds 1 cycle after req → grants alternate 0,1,0,1; each host_rvalid_o arrives 2 cycles after its grant.
REQ-021 Host 0 reads 0x1000_0004 with device 1 at base 0x1000_0000, mask 0xF000_0000; device returns rdata 0xDEADBEEF, err=0 → host_rvalid_o[0]=1, rdata=0xDEADBEEF, err=0; device_be_o[1] equals host_be_i[0].
REQ-022 Host 1 accesses an unmapped address 0xF000_0000 → no device_req_o; next cycle host_rvalid_o[1]=1, err=1, rdata=0.
REQ-023 Device never responds, TimeoutCycles=16 → host_rvalid_o with err=1 exactly 17 cycles after the grant; a later device_rvalid_i is ignored and produces no extra rvalid.
REQ-024 rst_ni driven low during WAIT for one cycle → no host_rvalid_o; the next request is granted to host 0 first.
REQ-025 Two devices overlap the address window, device_err_i=1 from device 0 → device 0 is selected and host_err_o=1 is reported.
